// File: rtl/ex_alu_if.sv
// ---------------------------------------------------------------------------
// tortoise_pkg / ex_alu_if
// Purpose : shared ALU op encoding and datapath widths, plus the issue and
//           writeback handshake bundle used by the ex_alu execute stage.
// Ports   : issue side    in_valid_i/in_ready_o, in_id_i, in_op_i,
//                         in_opa_i/in_opb_i/in_opc_i
//           writeback side out_valid_o/out_ready_i, out_id_o, out_result_o,
//                         out_cmp_o, out_target_o, out_jump_o, out_misalign_o
//           modport slave  = ALU view, modport master = issue/writeback view.
// ---------------------------------------------------------------------------
package tortoise_pkg;
  localparam int XLEN       = 64;
  localparam int TRANS_ID_W = 3;

  typedef enum logic [4:0] {
    ADD, SUB, ADDW, SUBW,
    XORL, ORL, ANDL,
    SRA, SRL, SLL, SRLW, SLLW, SRAW,
    CMP_LTS, CMP_GES, CMP_EQ, CMP_NE, CMP_LTU, CMP_GEU,
    JAL_R
  } fu_op_t;
endpackage

interface ex_alu_if;
  logic                                in_valid_i;
  logic                                in_ready_o;
  logic [tortoise_pkg::TRANS_ID_W-1:0] in_id_i;
  tortoise_pkg::fu_op_t                in_op_i;
  logic [tortoise_pkg::XLEN-1:0]       in_opa_i;
  logic [tortoise_pkg::XLEN-1:0]       in_opb_i;
  logic [tortoise_pkg::XLEN-1:0]       in_opc_i;

  logic                                out_valid_o;
  logic                                out_ready_i;
  logic [tortoise_pkg::TRANS_ID_W-1:0] out_id_o;
  logic [tortoise_pkg::XLEN-1:0]       out_result_o;
  logic                                out_cmp_o;
  logic [tortoise_pkg::XLEN-1:0]       out_target_o;
  logic                                out_jump_o;
  logic                                out_misalign_o;

  modport slave (
    input  in_valid_i, in_id_i, in_op_i, in_opa_i, in_opb_i, in_opc_i,
    output in_ready_o,
    output out_valid_o, out_id_o, out_result_o, out_cmp_o, out_target_o,
           out_jump_o, out_misalign_o,
    input  out_ready_i
  );

  modport master (
    output in_valid_i, in_id_i, in_op_i, in_opa_i, in_opb_i, in_opc_i,
    input  in_ready_o,
    input  out_valid_o, out_id_o, out_result_o, out_cmp_o, out_target_o,
           out_jump_o, out_misalign_o,
    output out_ready_i
  );
endinterface

// File: rtl/ex_alu.sv
// ---------------------------------------------------------------------------
// ex_alu
// Purpose : execute stage for ALU-class ops (OP, OPIMM, OP32, OPIMM32, AUIPC,
//           BRANCH, JALR). Two-stage pipeline: S1 registers the issued op,
//           S2 registers the computed result, compare outcome and JALR target.
// Ports   : clk_i   clock, rising edge
//           rstn_i  asynchronous active-low reset
//           flush_i kill every in-flight op and any same-cycle issue
//           bus     ex_alu_if.slave (issue handshake in, writeback handshake out)
// ---------------------------------------------------------------------------
module ex_alu
  import tortoise_pkg::*;
(
  input logic    clk_i,
  input logic    rstn_i,
  input logic    flush_i,
  ex_alu_if.slave bus
);

  // S1: accepted operands
  logic                  s1_valid_reg;
  logic [TRANS_ID_W-1:0] s1_id_reg;
  fu_op_t                s1_op_reg;
  logic [XLEN-1:0]       s1_opa_reg;
  logic [XLEN-1:0]       s1_opb_reg;
  logic [XLEN-1:0]       s1_opc_reg;

  // S2: registered outputs
  logic                  s2_valid_reg;
  logic [TRANS_ID_W-1:0] out_id_reg;
  logic [XLEN-1:0]       out_result_reg;
  logic                  out_cmp_reg;
  logic [XLEN-1:0]       out_target_reg;
  logic                  out_jump_reg;
  logic                  out_misalign_reg;

  // Stall chain: a stage may load when it is empty or its successor moves.
  logic adv1;
  logic adv2;
  assign adv2 = !s2_valid_reg | bus.out_ready_i;
  assign adv1 = !s1_valid_reg | adv2;
  assign bus.in_ready_o = adv1;

  // -------------------------------------------------------------------------
  // Combinational compute from S1 contents
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] result_next;
  logic            cmp_next;
  logic [XLEN-1:0] target_next;
  logic            jump_next;
  logic            misalign_next;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] jalr_target;
  logic [5:0]      shamt;
  logic [4:0]      shamt_w;
  logic [31:0]     a32;
  logic [31:0]     b32;
  logic [31:0]     add_w;
  logic [31:0]     sub_w;
  logic [31:0]     sll_w;
  logic [31:0]     srl_w;
  logic [31:0]     sra_w;
  logic            lts;
  logic            ltu;
  logic            eq;

  assign sum         = s1_opa_reg + s1_opb_reg;
  assign jalr_target = sum & ~64'h1;
  assign shamt       = s1_opb_reg[5:0];
  assign shamt_w     = s1_opb_reg[4:0];
  assign a32         = s1_opa_reg[31:0];
  assign b32         = s1_opb_reg[31:0];
  assign add_w       = a32 + b32;
  assign sub_w       = a32 - b32;
  assign sll_w       = a32 << shamt_w;
  assign srl_w       = a32 >> shamt_w;
  assign sra_w       = $unsigned($signed(a32) >>> shamt_w);
  assign lts         = $signed(s1_opa_reg) < $signed(s1_opb_reg);
  assign ltu         = s1_opa_reg < s1_opb_reg;
  assign eq          = s1_opa_reg == s1_opb_reg;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  always_comb begin
    result_next   = '0;
    cmp_next      = 1'b0;
    target_next   = '0;
    jump_next     = 1'b0;
    misalign_next = 1'b0;
    case (s1_op_reg)
      ADD:     result_next = sum;
      SUB:     result_next = s1_opa_reg - s1_opb_reg;
      ADDW:    result_next = sext32(add_w);
      SUBW:    result_next = sext32(sub_w);
      XORL:    result_next = s1_opa_reg ^ s1_opb_reg;
      ORL:     result_next = s1_opa_reg | s1_opb_reg;
      ANDL:    result_next = s1_opa_reg & s1_opb_reg;
      SLL:     result_next = s1_opa_reg << shamt;
      SRL:     result_next = s1_opa_reg >> shamt;
      SRA:     result_next = $unsigned($signed(s1_opa_reg) >>> shamt);
      SLLW:    result_next = sext32(sll_w);
      SRLW:    result_next = sext32(srl_w);
      SRAW:    result_next = sext32(sra_w);
      CMP_LTS: cmp_next = lts;
      CMP_GES: cmp_next = !lts;
      CMP_LTU: cmp_next = ltu;
      CMP_GEU: cmp_next = !ltu;
      CMP_EQ:  cmp_next = eq;
      CMP_NE:  cmp_next = !eq;
      JAL_R: begin
        result_next   = s1_opc_reg;
        target_next   = jalr_target;
        jump_next     = 1'b1;
        // no compressed ISA, so a target with bit 1 set is misaligned
        misalign_next = jalr_target[1];
      end
      default: result_next = '0;
    endcase
    // compare ops also write the outcome to rd as 0/1
    if (cmp_next) result_next = {{(XLEN-1){1'b0}}, 1'b1};
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_reg     <= 1'b0;
      s1_id_reg        <= '0;
      s1_op_reg        <= ADD;
      s1_opa_reg       <= '0;
      s1_opb_reg       <= '0;
      s1_opc_reg       <= '0;
      s2_valid_reg     <= 1'b0;
      out_id_reg       <= '0;
      out_result_reg   <= '0;
      out_cmp_reg      <= 1'b0;
      out_target_reg   <= '0;
      out_jump_reg     <= 1'b0;
      out_misalign_reg <= 1'b0;
    end else begin
      // Valid bits: a flush wins over everything, including a handshake
      // happening this very cycle. Data regs are left as-is on flush.
      if (flush_i) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
      end else begin
        if (adv2) s2_valid_reg <= s1_valid_reg;
        if (adv1) s1_valid_reg <= bus.in_valid_i;
      end

      if (adv1 && bus.in_valid_i) begin
        s1_id_reg  <= bus.in_id_i;
        s1_op_reg  <= bus.in_op_i;
        s1_opa_reg <= bus.in_opa_i;
        s1_opb_reg <= bus.in_opb_i;
        s1_opc_reg <= bus.in_opc_i;
      end

      // Outputs only move when S2 advances, which keeps them stable while
      // writeback is back-pressuring a valid result.
      if (adv2) begin
        out_id_reg       <= s1_id_reg;
        out_result_reg   <= result_next;
        out_cmp_reg      <= cmp_next;
        out_target_reg   <= target_next;
        out_jump_reg     <= jump_next;
        out_misalign_reg <= misalign_next;
      end
    end
  end

  assign bus.out_valid_o    = s2_valid_reg;
  assign bus.out_id_o       = out_id_reg;
  assign bus.out_result_o   = out_result_reg;
  assign bus.out_cmp_o      = out_cmp_reg;
  assign bus.out_target_o   = out_target_reg;
  assign bus.out_jump_o     = out_jump_reg;
  assign bus.out_misalign_o = out_misalign_reg;

endmodule

// File: tb/tb_ex_alu.sv
// ---------------------------------------------------------------------------
// tb_ex_alu
// Purpose : directed self-checking bench for ex_alu. Inputs are driven on the
//           falling edge, outputs are sampled on the falling edge (or 1 time
//           unit later for the combinational ready).
// ---------------------------------------------------------------------------
module tb_ex_alu;
  import tortoise_pkg::*;

  logic clk;
  logic rstn;
  logic flush;

  ex_alu_if bus ();

  ex_alu dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .flush_i(flush),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one op with out_ready high and wait for its result; returns at the
  // falling edge where the result is presented.
  task automatic run_op(input string tag, input fu_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [2:0] id);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_op_i     = op;
    bus.in_opa_i    = a;
    bus.in_opb_i    = b;
    bus.in_opc_i    = c;
    bus.in_id_i     = id;
    #1 check({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check({tag, "_lat1"}, 64'(bus.out_valid_o), 64'd0);
    @(negedge clk);
    check({tag, "_lat2"}, 64'(bus.out_valid_o), 64'd1);
    check({tag, "_id"}, 64'(bus.out_id_o), 64'(id));
  endtask

  // backpressure vectors
  fu_op_t      vop [4];
  logic [63:0] va  [4];
  logic [63:0] vb  [4];
  logic [2:0]  vid [4];
  logic [63:0] vres[4];
  int idx;
  int got;

  initial begin
    rstn            = 1'b0;
    flush           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_id_i     = '0;
    bus.in_op_i     = ADD;
    bus.in_opa_i    = '0;
    bus.in_opb_i    = '0;
    bus.in_opc_i    = '0;
    bus.out_ready_i = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_out_valid",  64'(bus.out_valid_o), 64'd0);
    check("rst_out_result", bus.out_result_o, 64'd0);
    check("rst_out_id",     64'(bus.out_id_o), 64'd0);
    check("rst_out_target", bus.out_target_o, 64'd0);
    check("rst_out_jump",   64'(bus.out_jump_o), 64'd0);
    rstn = 1'b1;
    #1 check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

    // ---------------- arithmetic ----------------
    run_op("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'd1);
    check("add_wrap_res", bus.out_result_o, 64'd0);
    check("add_wrap_cmp", 64'(bus.out_cmp_o), 64'd0);
    check("add_wrap_jump", 64'(bus.out_jump_o), 64'd0);

    run_op("addw", ADDW, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd0, 3'd2);
    check("addw_res", bus.out_result_o, 64'hFFFF_FFFF_8000_0000);

    run_op("sraw", SRAW, 64'h0000_0000_8000_0000, 64'd4, 64'd0, 3'd3);
    check("sraw_res", bus.out_result_o, 64'hFFFF_FFFF_F800_0000);

    run_op("sra", SRA, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 3'd4);
    check("sra_res", bus.out_result_o, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op("sll_mask", SLL, 64'd1, 64'h43, 64'd0, 3'd5);
    check("sll_mask_res", bus.out_result_o, 64'd8);

    run_op("subw", SUBW, 64'd0, 64'd1, 64'd0, 3'd6);
    check("subw_res", bus.out_result_o, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op("srlw", SRLW, 64'hFFFF_FFFF_8000_0000, 64'h24, 64'd0, 3'd7);
    check("srlw_res", bus.out_result_o, 64'h0000_0000_0800_0000);

    run_op("orl", ORL, 64'hF0, 64'h0F, 64'd0, 3'd0);
    check("orl_res", bus.out_result_o, 64'hFF);

    // ---------------- compares ----------------
    run_op("lts", CMP_LTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'd1);
    check("lts_cmp", 64'(bus.out_cmp_o), 64'd1);
    check("lts_res", bus.out_result_o, 64'd1);

    run_op("ltu", CMP_LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'd2);
    check("ltu_cmp", 64'(bus.out_cmp_o), 64'd0);
    check("ltu_res", bus.out_result_o, 64'd0);

    run_op("ges", CMP_GES, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'd3);
    check("ges_cmp", 64'(bus.out_cmp_o), 64'd0);

    run_op("ne", CMP_NE, 64'd3, 64'd3, 64'd0, 3'd4);
    check("ne_cmp", 64'(bus.out_cmp_o), 64'd0);

    // ---------------- JAL_R ----------------
    run_op("jalr_mis", JAL_R, 64'h1000, 64'h7, 64'h2004, 3'd5);
    check("jalr_mis_target", bus.out_target_o, 64'h1006);
    check("jalr_mis_result", bus.out_result_o, 64'h2004);
    check("jalr_mis_jump",   64'(bus.out_jump_o), 64'd1);
    check("jalr_mis_mis",    64'(bus.out_misalign_o), 64'd1);
    check("jalr_mis_cmp",    64'(bus.out_cmp_o), 64'd0);

    run_op("jalr_ok", JAL_R, 64'h1000, 64'h5, 64'h2004, 3'd6);
    check("jalr_ok_target", bus.out_target_o, 64'h1004);
    check("jalr_ok_mis",    64'(bus.out_misalign_o), 64'd0);

    // ---------------- backpressure: 4 back-to-back ops ----------------
    vop[0] = ADD;    va[0] = 64'd10;   vb[0] = 64'd20;   vid[0] = 3'd5; vres[0] = 64'h1E;
    vop[1] = SUB;    va[1] = 64'd5;    vb[1] = 64'd7;    vid[1] = 3'd6; vres[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    vop[2] = XORL;   va[2] = 64'hF0F0; vb[2] = 64'hFF00; vid[2] = 3'd7; vres[2] = 64'h0FF0;
    vop[3] = CMP_EQ; va[3] = 64'd123;  vb[3] = 64'd123;  vid[3] = 3'd0; vres[3] = 64'd1;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready_i = (cyc >= 5);
      bus.in_valid_i  = (idx < 4);
      if (idx < 4) begin
        bus.in_op_i  = vop[idx];
        bus.in_opa_i = va[idx];
        bus.in_opb_i = vb[idx];
        bus.in_opc_i = 64'd0;
        bus.in_id_i  = vid[idx];
      end
      #1;
      if (cyc == 2) begin
        check("bp_ready_drop", 64'(bus.in_ready_o), 64'd0);
        check("bp_accepts",    64'(idx), 64'd2);
      end
      if (bus.out_valid_o && !bus.out_ready_i) begin
        check("bp_hold_id",  64'(bus.out_id_o), 64'(vid[got]));
        check("bp_hold_res", bus.out_result_o, vres[got]);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        check("bp_out_id",  64'(bus.out_id_o), 64'(vid[got]));
        check("bp_out_res", bus.out_result_o, vres[got]);
        got++;
      end
      if (bus.in_valid_i && bus.in_ready_o) idx++;
    end
    bus.in_valid_i = 1'b0;
    check("bp_all_out", 64'(got), 64'd4);

    // ---------------- flush: two ops in flight, stalled ----------------
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1; bus.in_op_i = ADD; bus.in_opa_i = 64'd1; bus.in_opb_i = 64'd1; bus.in_id_i = 3'd1;
    @(negedge clk);
    bus.in_id_i = 3'd2;
    @(negedge clk);
    bus.in_id_i = 3'd3;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("flush1_no_valid", 64'(bus.out_valid_o), 64'd0);
      @(negedge clk);
    end

    // ---------------- flush: one in S1 plus a same-cycle handshake --------
    bus.in_valid_i = 1'b1; bus.in_id_i = 3'd4;
    @(negedge clk);
    bus.in_id_i = 3'd5;
    flush = 1'b1;
    #1 check("flush2_handshake", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush2_no_valid", 64'(bus.out_valid_o), 64'd0);
      @(negedge clk);
    end

    run_op("post_flush", ADD, 64'd40, 64'd2, 64'd0, 3'd6);
    check("post_flush_res", bus.out_result_o, 64'd42);

    // ---------------- async reset with an op in flight ----------------
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.in_op_i = ADD; bus.in_opa_i = 64'd7; bus.in_opb_i = 64'd7; bus.in_id_i = 3'd7;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #2 rstn = 1'b0;
    #1 check("rst_mid_result", bus.out_result_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_valid", 64'(bus.out_valid_o), 64'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
